// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: captures one load/store request,
// inserts WAIT_CYCLES wait states, then accesses word storage and holds the
// response until the processor takes it.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_length,
  input  logic        req_sign,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        cap_write;
  logic [31:0] cap_addr;
  logic [1:0]  cap_length;
  logic        cap_sign;
  logic [31:0] cap_wdata;

  logic [31:0] mem [DEPTH_WORDS];

  logic          accept;
  logic          enter_resp;
  logic          acc_write;
  logic [31:0]   acc_addr;
  logic [1:0]    acc_length;
  logic          acc_sign;
  logic [31:0]   acc_wdata;
  logic          fault;
  logic [AW-1:0] idx;
  logic [31:0]   word_old;
  logic [31:0]   word_new;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   rdata_nx;

  // Access decode: with zero wait states the access happens on the accept
  // edge, so it must use the live request rather than the captured copy.
  always_comb begin
    accept     = 1'b0;
    enter_resp = 1'b0;
    acc_write  = cap_write;
    acc_addr   = cap_addr;
    acc_length = cap_length;
    acc_sign   = cap_sign;
    acc_wdata  = cap_wdata;

    if (state == IDLE) begin
      accept     = req_valid && req_ready;
      acc_write  = req_write;
      acc_addr   = req_addr;
      acc_length = req_length;
      acc_sign   = req_sign;
      acc_wdata  = req_wdata;
      enter_resp = accept && (WAIT_CYCLES == 0);
    end else if (state == WAIT) begin
      enter_resp = (cnt == 4'd1);
    end

    fault = (acc_length == 2'b11)
         || ((acc_length == 2'b01) && acc_addr[0])
         || ((acc_length == 2'b10) && (acc_addr[1:0] != 2'b00))
         || ({2'b00, acc_addr[31:2]} >= 32'(DEPTH_WORDS));

    idx      = acc_addr[AW+1:2];
    word_old = mem[idx];
    byte_sel = word_old[{acc_addr[1:0], 3'b000} +: 8];
    half_sel = word_old[{acc_addr[1], 4'b0000} +: 16];

    word_new = word_old;
    case (acc_length)
      2'b00:   word_new[{acc_addr[1:0], 3'b000} +: 8] = acc_wdata[7:0];
      2'b01:   word_new[{acc_addr[1], 4'b0000} +: 16] = acc_wdata[15:0];
      default: word_new = acc_wdata;
    endcase

    case (acc_length)
      2'b00:   rdata_nx = acc_sign ? {{24{byte_sel[7]}}, byte_sel} : {24'h0, byte_sel};
      2'b01:   rdata_nx = acc_sign ? {{16{half_sel[15]}}, half_sel} : {16'h0, half_sel};
      default: rdata_nx = word_old;
    endcase
    if (fault || acc_write) begin
      rdata_nx = 32'h0;
    end
  end

  // Storage commit: only on the edge entering RESP for a non-faulting store.
  always_ff @(posedge clk) begin
    if (rst && enter_resp && acc_write && !fault) begin
      mem[idx] <= word_new;
    end
  end

  // Control FSM with registered handshake and response outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cap_write  <= req_write;
            cap_addr   <= req_addr;
            cap_length <= req_length;
            cap_sign   <= req_sign;
            cap_wdata  <= req_wdata;
            req_ready  <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= rdata_nx;
              rsp_err   <= fault;
            end else begin
              state <= WAIT;
              cnt   <= 4'(WAIT_CYCLES);
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt == 4'd1) begin
            state     <= RESP;
            cnt       <= 4'd0;
            rsp_valid <= 1'b1;
            rsp_rdata <= rdata_nx;
            rsp_err   <= fault;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder (DEPTH_WORDS=1024, WAIT_CYCLES=2).
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [1:0]  req_length;
  logic        req_sign;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_chk = 0;
  int n_bad = 0;

  logic [32:0] sb [$];          // {err, rdata}
  logic [31:0] mdl [0:7];       // reference words at 0x100..0x11C

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_length(req_length), .req_sign(req_sign),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference behaviour for the random phase; region 0x100..0x11F is in range.
  function automatic logic [32:0] model(input logic w, input logic [31:0] a,
                                        input logic [1:0] len, input logic sg,
                                        input logic [31:0] wd);
    int          wi = int'((a - 32'h100) >> 2);
    int          sh = int'(a[1:0]) * 8;
    logic [31:0] wv = mdl[wi];
    logic [31:0] m;
    logic [31:0] v;
    if (len == 2'd3 || (len == 2'd1 && a[0]) || (len == 2'd2 && a[1:0] != 2'd0))
      return {1'b1, 32'h0};
    m = (len == 2'd0) ? 32'hFF : (len == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
    if (w) begin
      mdl[wi] = (wv & ~(m << sh)) | ((wd & m) << sh);
      return 33'h0;
    end
    v = (wv >> sh) & m;
    if (sg && len == 2'd0 && v[7])  v = v | 32'hFFFF_FF00;
    if (sg && len == 2'd1 && v[15]) v = v | 32'hFFFF_0000;
    return {1'b0, v};
  endfunction

  // One request/response; optional back-pressure or reset in WAIT / RESP.
  task automatic xact(input logic w, input logic [31:0] a, input logic [1:0] len,
                      input logic sg, input logic [31:0] wd, input logic [32:0] expv,
                      input int hold, input bit rst_wait, input bit rst_resp);
    int          n;
    int          lat;
    logic [32:0] e;
    logic [31:0] held;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("req_ready_before_req", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_length = len;
    req_sign = sg; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    if (rst_wait) begin
      chk("no_valid_in_wait", 32'(rsp_valid), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("ready_after_rst", 32'(req_ready), 32'd1);
      return;
    end
    sb.push_back(expv);
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    chk("latency", 32'(lat), 32'd3);
    if (sb.size() == 0) begin
      chk("scoreboard_underflow", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("rsp_rdata", rsp_rdata, e[31:0]);
      chk("rsp_err", 32'(rsp_err), 32'(e[32]));
    end
    if (rst_resp) begin
      rst = 1'b0;
      @(negedge clk);
      chk("rst_drops_valid", 32'(rsp_valid), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("ready_after_rst_resp", 32'(req_ready), 32'd1);
      return;
    end
    held = rsp_rdata;
    for (int k = 0; k < hold; k++) begin
      if (k == 1) begin
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10;
        req_length = 2'd2; req_wdata = 32'h0;
      end
      @(negedge clk);
      req_valid = 1'b0;
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_rdata", rsp_rdata, held);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("valid_drops_after_hs", 32'(rsp_valid), 32'd0);
    chk("ready_in_idle", 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic        w;
    logic [31:0] a;
    logic [1:0]  len;
    logic        sg;
    logic [31:0] wd;
    rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0;
    req_length = 2'd0; req_sign = 1'b0; req_wdata = 32'h0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_first_cycle", 32'(req_ready), 32'd1);

    // word store then load, sub-word loads
    xact(1, 32'h10, 2'd2, 0, 32'hDEADBEEF, 33'h0, 0, 0, 0);
    xact(0, 32'h10, 2'd2, 1, 32'h0, {1'b0, 32'hDEADBEEF}, 0, 0, 0);
    xact(0, 32'h13, 2'd0, 1, 32'h0, {1'b0, 32'hFFFFFFDE}, 0, 0, 0);
    xact(0, 32'h13, 2'd0, 0, 32'h0, {1'b0, 32'h000000DE}, 0, 0, 0);
    xact(0, 32'h10, 2'd1, 1, 32'h0, {1'b0, 32'hFFFFBEEF}, 0, 0, 0);
    xact(0, 32'h12, 2'd1, 0, 32'h0, {1'b0, 32'h0000DEAD}, 0, 0, 0);
    // partial store
    xact(1, 32'h11, 2'd0, 0, 32'hAAAAAA55, 33'h0, 0, 0, 0);
    xact(0, 32'h10, 2'd2, 0, 32'h0, {1'b0, 32'hDEAD55EF}, 0, 0, 0);
    // faults
    xact(0, 32'h11, 2'd1, 0, 32'h0, {1'b1, 32'h0}, 0, 0, 0);
    xact(1, 32'h12, 2'd2, 0, 32'hFFFFFFFF, {1'b1, 32'h0}, 0, 0, 0);
    xact(0, 32'h10, 2'd3, 0, 32'h0, {1'b1, 32'h0}, 0, 0, 0);
    xact(1, 32'h1000, 2'd2, 0, 32'h11111111, {1'b1, 32'h0}, 0, 0, 0);
    xact(0, 32'h10, 2'd2, 0, 32'h0, {1'b0, 32'hDEAD55EF}, 0, 0, 0);
    // back-pressure with a stray request, then confirm it was not captured
    xact(0, 32'h10, 2'd2, 0, 32'h0, {1'b0, 32'hDEAD55EF}, 5, 0, 0);
    xact(0, 32'h10, 2'd2, 0, 32'h0, {1'b0, 32'hDEAD55EF}, 0, 0, 0);
    // reset mid-store discards the store
    xact(1, 32'h20, 2'd2, 0, 32'hCAFEF00D, 33'h0, 0, 0, 0);
    xact(1, 32'h20, 2'd2, 0, 32'h12345678, 33'h0, 0, 1, 0);
    xact(0, 32'h20, 2'd2, 0, 32'h0, {1'b0, 32'hCAFEF00D}, 0, 0, 0);
    // reset in RESP drops the response; storage survives reset
    xact(0, 32'h10, 2'd2, 0, 32'h0, {1'b0, 32'hDEAD55EF}, 0, 0, 1);
    xact(0, 32'h10, 2'd2, 0, 32'h0, {1'b0, 32'hDEAD55EF}, 0, 0, 0);

    // random traffic against the reference model
    for (int i = 0; i < 8; i++) begin
      wd = $urandom;
      mdl[i] = 32'h0;
      a = 32'h100 + 32'(i * 4);
      xact(1, a, 2'd2, 0, wd, model(1'b1, a, 2'd2, 1'b0, wd), 0, 0, 0);
    end
    for (int i = 0; i < 40; i++) begin
      w   = 1'($urandom_range(0, 1));
      a   = 32'h100 + 32'($urandom_range(0, 31));
      len = 2'($urandom_range(0, 3));
      sg  = 1'($urandom_range(0, 1));
      wd  = $urandom;
      xact(w, a, len, sg, wd, model(w, a, len, sg, wd), (i % 7 == 3) ? 2 : 0, 0, 0);
    end

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
